step_counter: RTL and testbench

Parametrised registered incrementer/decrementer and the next generation of the fixed 7-bit add-two register. Supports a loadable start value, run-time step size, up/down direction, and wrap or saturate overflow mode. Registered overflow and saturation event flags let downstream logic count wraps or detect end-of-range. Used as a general address/index stepper in sequential datapaths.

---
 rtl/step_counter_if.sv | 25 ++
 rtl/step_counter.sv | 73 +++++++
 tb/tb_step_counter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/step_counter_if.sv
// rtl/step_counter_if.sv - control/data bundle between a step_counter and its driver
interface step_counter_if #(
    parameter int WIDTH      = 7,
    parameter int STEP_WIDTH = 3
);
    logic                  load;
    logic [WIDTH-1:0]      d;
    logic                  en;
    logic [STEP_WIDTH-1:0] step;
    logic                  dir;
    logic                  sat;
    logic [WIDTH-1:0]      q;
    logic                  wrapped;
    logic                  sat_hit;

    modport master (
        output load, d, en, step, dir, sat,
        input  q, wrapped, sat_hit
    );

    modport slave (
        input  load, d, en, step, dir, sat,
        output q, wrapped, sat_hit
    );
endinterface

// File: rtl/step_counter.sv
// rtl/step_counter.sv - registered loadable up/down stepper with wrap/saturate event flags
module step_counter #(
    parameter int WIDTH      = 7,
    parameter int STEP_WIDTH = 3,
    parameter int RESET_VAL  = 0
) (
    input  logic          clk,
    input  logic          reset,
    step_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             wrapped_r;
    logic             wrapped_nxt;
    logic             sat_hit_r;
    logic             sat_hit_nxt;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // One extra bit on top carries the overflow (up) or borrow (down).
    assign step_ext = {{(WIDTH + 1 - STEP_WIDTH){1'b0}}, bus.step};
    assign sum      = {1'b0, q_r} + step_ext;
    assign diff     = {1'b0, q_r} - step_ext;

    // Next value and event flags: load beats en, en beats hold.
    always_comb begin
        q_nxt       = q_r;
        wrapped_nxt = 1'b0;
        sat_hit_nxt = 1'b0;
        if (bus.load) begin
            q_nxt = bus.d;
        end else if (bus.en) begin
            if (!bus.dir) begin
                if (sum[WIDTH] && bus.sat) begin
                    q_nxt       = MAX_VAL;
                    sat_hit_nxt = 1'b1;
                end else begin
                    q_nxt       = sum[WIDTH-1:0];
                    wrapped_nxt = sum[WIDTH];
                end
            end else begin
                if (diff[WIDTH] && bus.sat) begin
                    q_nxt       = '0;
                    sat_hit_nxt = 1'b1;
                end else begin
                    q_nxt       = diff[WIDTH-1:0];
                    wrapped_nxt = diff[WIDTH];
                end
            end
        end
    end

    // State register; reset acts immediately and drops any pending update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r       <= RST_Q;
            wrapped_r <= 1'b0;
            sat_hit_r <= 1'b0;
        end else begin
            q_r       <= q_nxt;
            wrapped_r <= wrapped_nxt;
            sat_hit_r <= sat_hit_nxt;
        end
    end

    assign bus.q       = q_r;
    assign bus.wrapped = wrapped_r;
    assign bus.sat_hit = sat_hit_r;
endmodule

// File: tb/tb_step_counter.sv
// tb/tb_step_counter.sv - scoreboard bench for step_counter against an integer reference model
module tb_step_counter;
    localparam int W   = 7;
    localparam int SW  = 3;
    localparam int RV  = 0;
    localparam int MAX = (1 << W) - 1;

    typedef struct {
        int q;
        int w;
        int s;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   m_q;
    int   n_checks;
    int   n_fail;

    step_counter_if #(.WIDTH(W), .STEP_WIDTH(SW)) bus ();

    step_counter #(.WIDTH(W), .STEP_WIDTH(SW), .RESET_VAL(RV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endfunction

    // Drive one cycle of stimulus at the falling edge and push what the model predicts.
    task automatic drive(input bit rst, input bit ld, input int dv, input bit e,
                         input int st, input bit dr, input bit sa);
        exp_t x;
        int   t;
        logic [31:0] dvec;
        logic [31:0] svec;
        dvec = dv;
        svec = st;
        @(negedge clk);
        reset    = rst;
        bus.load = ld;
        bus.d    = dvec[W-1:0];
        bus.en   = e;
        bus.step = svec[SW-1:0];
        bus.dir  = dr;
        bus.sat  = sa;
        x = '{q: 0, w: 0, s: 0};
        if (rst) begin
            m_q = RV;
        end else if (ld) begin
            m_q = dv;
        end else if (e) begin
            t = dr ? (m_q - st) : (m_q + st);
            if (t > MAX || t < 0) begin
                if (sa) begin
                    m_q = (t > MAX) ? MAX : 0;
                    x.s = 1;
                end else begin
                    m_q = (t > MAX) ? t - (MAX + 1) : t + (MAX + 1);
                    x.w = 1;
                end
            end else begin
                m_q = t;
            end
        end
        x.q = m_q;
        exp_q.push_back(x);
    endtask

    // Monitor: every rising edge delivers one result; compare it to the oldest prediction.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("q", 32'(bus.q), x.q);
                check("wrapped", 32'(bus.wrapped), x.w);
                check("sat_hit", 32'(bus.sat_hit), x.s);
                check("flags_exclusive", 32'(bus.wrapped & bus.sat_hit), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_q      = RV;
        reset    = 1'b1;
        bus.load = 1'b0;
        bus.d    = '0;
        bus.en   = 1'b0;
        bus.step = '0;
        bus.dir  = 1'b0;
        bus.sat  = 1'b0;
        #1;
        check("reset_q_async", 32'(bus.q), RV);
        check("reset_flags_async", 32'({bus.wrapped, bus.sat_hit}), 0);

        // Add-two compatibility
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 2, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 2, 0, 0);
        // Wrap up then hold
        drive(0, 1, 126, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        // Saturate up twice, then idle
        drive(0, 1, 126, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 0, 1);
        drive(0, 0, 0, 1, 3, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        // Down: wrap, saturate, exact landing on zero
        drive(0, 1, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 2, 1, 0);
        drive(0, 1, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 2, 1, 1);
        drive(0, 1, 2, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 2, 1, 1);
        // Exact landing on the top bound
        drive(0, 1, 120, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 7, 0, 1);
        // Load beats en; zero step
        drive(0, 1, 50, 1, 7, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 1);

        // Reset between edges while counting up
        drive(0, 0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midcycle_reset_q", 32'(bus.q), RV);
        check("midcycle_reset_flags", 32'({bus.wrapped, bus.sat_hit}), 0);
        m_q = RV;
        drive(0, 0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            bit r;
            bit ld;
            bit e;
            r  = ($urandom_range(0, 59) == 0);
            ld = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            drive(r, ld, $urandom_range(0, MAX), e, $urandom_range(0, (1 << SW) - 1),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
